// File: rtl/score_ssd_pkg.sv
// Shared definitions for the score seven-segment driver.
// Holds the conversion FSM state type, display geometry and the active-low
// segment patterns (bit order {Ca,Cb,Cc,Cd,Ce,Cf,Cg}) plus a nibble encoder.
package score_ssd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StShift  = 2'd2,
    StCommit = 2'd3
  } conv_state_e;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned SCAN_SLOTS = 8;
  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-decimal nibbles render dark rather than a garbage glyph.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to five BCD digits.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   start_i         request a conversion; accepted only while idle
//   bin_i           binary value, sampled in the LOAD cycle
//   busy_o          high in LOAD and SHIFT
//   load_o          high in the cycle bin_i is captured
//   done_o          one-cycle pulse; bcd_o holds the finished result then
//   bcd_o           20-bit packed BCD accumulator, digit 0 in bits [3:0]
module bin2bcd_seq
  import score_ssd_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             load_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  conv_state_e      state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_adj;

  // Add-3 correction so each nibble carries correctly after the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        bin_d   = bin_i;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        // Sixteen shifts: cnt runs 0..15.
        if (cnt_q == 4'd15) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == StLoad) || (state_q == StShift);
  assign load_o = (state_q == StLoad);
  assign done_o = (state_q == StCommit);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_ssd_driver.sv
// Seven-segment driver for the zombies-killed score.
// Converts the binary score to BCD whenever it changes and scans the five
// digits over eight active-low anodes, optionally blanking leading zeros.
// Ports:
//   clk, reset     100 MHz clock, synchronous active-high reset
//   displayNumber  unsigned 16-bit score
//   anode          active-low anode enables, bit 0 = rightmost digit (registered)
//   ssdOut         active-low segments {Ca..Cg} (registered)
//   Dp             decimal point, held off
//   busy           high while a conversion is in progress
module score_ssd_driver
  import score_ssd_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      displayNumber,
  output logic [SCAN_SLOTS-1:0] anode,
  output logic [6:0]            ssdOut,
  output logic                  Dp,
  output logic                  busy
);

  localparam int unsigned CntW          = REFRESH_BITS + 3;
  localparam logic [2:0]  LastDigitSlot = 3'(NUM_DIGITS - 1);

  logic [BIN_W-1:0]      last_value_q;
  logic                  valid_q;
  logic [BCD_W-1:0]      digits_q;
  logic [CntW-1:0]       refresh_q;
  logic [SCAN_SLOTS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;

  logic             start, load, done;
  logic [BCD_W-1:0] bcd;
  logic [2:0]       slot;
  logic [3:0]       nib;
  logic             lead_zero;

  // Only honoured while the converter is idle, so mid-conversion changes are
  // picked up by this compare once COMMIT has finished.
  assign start = !valid_q || (displayNumber != last_value_q);

  bin2bcd_seq u_bin2bcd (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .bin_i   (displayNumber),
    .busy_o  (busy),
    .load_o  (load),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  always_comb begin
    slot      = refresh_q[REFRESH_BITS +: 3];
    nib       = digits_q[{slot, 2'b00} +: 4];
    // Current digit and every more-significant digit are zero.
    lead_zero = ((digits_q >> {slot, 2'b00}) == '0);
    anode_d   = '1;
    seg_d     = SEG_BLANK;
    if (slot <= LastDigitSlot) begin
      if (!(LZ_BLANK && (slot != 3'd0) && lead_zero)) begin
        anode_d[slot] = 1'b0;
        seg_d         = seg_encode(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_value_q <= '0;
      valid_q      <= 1'b0;
      digits_q     <= '0;
      refresh_q    <= '0;
      anode_q      <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      // Captured on the same edge the converter samples its operand.
      if (load) last_value_q <= displayNumber;
      if (done) begin
        digits_q <= bcd;
        valid_q  <= 1'b1;
      end
      refresh_q <= refresh_q + CntW'(1);
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign anode  = anode_q;
  assign ssdOut = seg_q;
  assign Dp     = 1'b1;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Bench for score_ssd_driver: two instances (leading-zero blanking on/off)
// share stimulus and are compared every cycle against a time-based model.
module tb_score_ssd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dn  = 16'd0;

  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, busy_a, busy_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_ssd_driver #(.REFRESH_BITS(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(rst), .displayNumber(dn),
    .anode(an_a), .ssdOut(seg_a), .Dp(dp_a), .busy(busy_a)
  );

  score_ssd_driver #(.REFRESH_BITS(2), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .reset(rst), .displayNumber(dn),
    .anode(an_b), .ssdOut(seg_b), .Dp(dp_b), .busy(busy_b)
  );

  int         pow10 [5]   = '{1, 10, 100, 1000, 10000};
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Model state: elapsed cycles since a conversion was accepted (-1 idle).
  int         m_cnt = 0, m_ph = -1, m_last = 0, m_cap = 0, m_shown = 0;
  bit         m_valid = 1'b0, m_busy = 1'b0;
  logic [7:0] ea_an = 8'hFF, eb_an = 8'hFF;
  logic [6:0] ea_seg = 7'h7F, eb_seg = 7'h7F;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t dn=%0d)", tag, got, exp, $time, dn);
    end
  endtask

  function automatic logic [19:0] bcd_of(input int v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
    return r;
  endfunction

  function automatic void exp_scan(input int cnt, input int shown, input bit lz,
                                   output logic [7:0] an, output logic [6:0] seg);
    int s;
    s   = cnt / 4;
    an  = 8'hFF;
    seg = 7'h7F;
    if (s < 5) begin
      if (!(lz && s > 0 && shown < pow10[s])) begin
        an[s] = 1'b0;
        seg   = seg_tab[(shown / pow10[s]) % 10];
      end
    end
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 1'b0; m_last = 0; m_shown = 0; m_ph = -1; m_cnt = 0;
      ea_an = 8'hFF; eb_an = 8'hFF; ea_seg = 7'h7F; eb_seg = 7'h7F;
    end else begin
      exp_scan(m_cnt, m_shown, 1'b1, ea_an, ea_seg);
      exp_scan(m_cnt, m_shown, 1'b0, eb_an, eb_seg);
      m_cnt = (m_cnt + 1) % 32;
      if (m_ph < 0) begin
        if (!m_valid || int'(dn) != m_last) m_ph = 0;
      end else begin
        m_ph++;
        if (m_ph == 1) begin
          m_cap  = int'(dn);
          m_last = m_cap;
        end
        if (m_ph == 18) begin
          m_shown = m_cap;
          m_valid = 1'b1;
          m_ph    = -1;
        end
      end
    end
    m_busy = (m_ph >= 0) && (m_ph <= 16);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("anode_lz", 32'(an_a), 32'(ea_an));
    check_eq("seg_lz", 32'(seg_a), 32'(ea_seg));
    check_eq("anode_nolz", 32'(an_b), 32'(eb_an));
    check_eq("seg_nolz", 32'(seg_b), 32'(eb_seg));
    check_eq("busy", 32'(busy_a), 32'(m_busy));
    check_eq("busy_nolz", 32'(busy_b), 32'(m_busy));
    check_eq("dp", 32'({dp_a, dp_b}), 32'd3);
    check_eq("digits", 32'(dut.digits_q), 32'(bcd_of(m_shown)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait (bounded) for a given anode pattern, then check the fixed glyph.
  task automatic see_slot(input string tag, input bit nolz, input logic [7:0] an,
                          input logic [6:0] seg);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if ((nolz ? an_b : an_a) == an) found = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
    if (found) check_eq(tag, 32'(nolz ? seg_b : seg_a), 32'(seg));
  endtask

  task automatic wait_ph(input int ph);
    for (int i = 0; i < 60 && m_ph != ph; i++) step();
    check_eq("phase_reached", 32'(m_ph), 32'(ph));
  endtask

  int          hold;
  int          bnd [9] = '{9, 10, 99, 100, 999, 1000, 9999, 10000, 65535};

  initial begin
    rst = 1'b1;
    dn  = 16'd0;
    run(3);
    rst = 1'b0;
    run(20);
    see_slot("zero_slot0", 1'b0, 8'hFE, 7'b0000001);
    run(30);

    dn = 16'd12345;
    run(20);
    see_slot("s4_1", 1'b0, 8'hEF, 7'b1001111);
    see_slot("s0_5", 1'b0, 8'hFE, 7'b0100100);
    run(20);

    dn = 16'd65535;
    run(20);
    see_slot("s4_6", 1'b0, 8'hEF, 7'b0100000);
    see_slot("s1_3", 1'b0, 8'hFD, 7'b0000110);

    dn = 16'd7;
    run(20);
    see_slot("s0_7", 1'b0, 8'hFE, 7'b0001111);
    see_slot("nolz_s2_0", 1'b1, 8'hFB, 7'b0000001);
    run(35);

    // Input change while shifting: 100 commits first, then 250.
    dn = 16'd100;
    wait_ph(6);
    dn = 16'd250;
    run(60);

    // Reset mid-conversion, then reconversion of the held value.
    dn = 16'd4321;
    wait_ph(8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(50);

    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 3))
        0:       dn = 16'($urandom_range(0, 99));
        1:       dn = 16'($urandom);
        2:       dn = 16'(bnd[$urandom_range(0, 8)]);
        default: dn = 16'($urandom_range(0, 9999));
      endcase
      hold = int'($urandom_range(1, 45));
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 199) == 0) rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
